// File: rtl/tt_um_ejfogleman_smsdac8_core_if.sv
// tt_um_ejfogleman_smsdac8_core_if: DAC code input and unit-element drive bundle
// master drives ena/ui_in/uio_in and observes the element drives; slave is the DAC core
interface tt_um_ejfogleman_smsdac8_core_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_um_ejfogleman_smsdac8_core.sv
// tt_um_ejfogleman_smsdac8_core: 8-bit segmented mismatch-shaping DAC encoder driving 14 unit elements
// clk: rising-edge clock; rst_n: synchronous reset, active HIGH despite the name
// bus.ena: run/freeze; bus.ui_in: code x; bus.uio_in: ignored
// bus.uo_out/bus.uio_out[7:2]: element drives, pair k weight 2^k; bus.uio_oe: constant 0xFC
// Optional macro SMSDAC_DITHER_EN adds a 16-bit LFSR that randomly suppresses pair toggles
module tt_um_ejfogleman_smsdac8_core (
  input logic clk,
  input logic rst_n,
  tt_um_ejfogleman_smsdac8_core_if.slave bus
);
  logic [7:0]  n;
  logic [7:0]  r;
  logic [13:0] elem_d, elem_q;
  logic [6:0]  s_d, s_q;
  logic [6:0]  hold;
  logic        unused_ok;
  assign unused_ok = &{1'b0, bus.uio_in};
  assign n = &bus.ui_in ? 8'd254 : bus.ui_in;
`ifdef SMSDAC_DITHER_EN
  localparam logic [15:0] SEED = 16'hACE1;
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign hold = lfsr_q[6:0];
  always_ff @(posedge clk)
    if (rst_n) lfsr_q <= SEED;
    else if (bus.ena) lfsr_q <= lfsr_d;
`else
  assign hold = '0;
`endif
  // Peel layers from LSB up: an odd quotient forces one element chosen by s_k;
  // an even quotient fills both elements only when higher pairs cannot hold the remainder.
  always_comb begin
    r = n;
    elem_d = '0;
    s_d = s_q;
    for (int k = 0; k < 7; k++) begin
      if (r[k]) begin
        elem_d[2*k+1] = ~s_q[k];
        elem_d[2*k] = s_q[k];
        s_d[k] = s_q[k] ^ ~hold[k];
        r = r - 8'(1 << k);
      end else if (r > 8'(256 - (4 << k))) begin
        elem_d[2*k +: 2] = 2'b11;
        r = r - 8'(2 << k);
      end
    end
  end
  always_ff @(posedge clk)
    if (rst_n) begin
      elem_q <= '0;
      s_q <= '0;
    end else if (bus.ena) begin
      elem_q <= elem_d;
      s_q <= s_d;
    end else
      elem_q <= '0;
  assign bus.uo_out = elem_q[13:6];
  assign bus.uio_out = {elem_q[5:0], 2'b00};
  assign bus.uio_oe = 8'hFC;
endmodule

// File: tb/tb_tt_um_ejfogleman_smsdac8_core.sv
// tb_tt_um_ejfogleman_smsdac8_core: random and directed check of the DAC encoder against a layer-peeling model
module tb_tt_um_ejfogleman_smsdac8_core;
  logic clk = 1'b0;
  logic rst_n;
  int n_cmp = 0;
  int n_bad = 0;
  tt_um_ejfogleman_smsdac8_core_if bus ();
  tt_um_ejfogleman_smsdac8_core dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask
  function automatic int dac_v(input logic [7:0] uo, input logic [7:0] uio);
    logic [13:0] e;
    int v;
    e = {uo, uio[7:2]};
    v = 0;
    for (int k = 0; k < 7; k++) v += (int'(e[2*k]) + int'(e[2*k+1])) * (1 << k);
    return v;
  endfunction
  logic [13:0] m_exp;
  int m_n;
  bit m_s [7];
  bit m_valid = 0;
  bit m_rst = 0;
  always @(posedge clk) begin
    int r, q;
    if (rst_n) begin
      foreach (m_s[k]) m_s[k] = 0;
      m_exp = '0;
      m_n = 0;
      m_valid = 1;
      m_rst = 1;
    end else begin
      m_rst = 0;
      if (bus.ena) begin
        m_n = bus.ui_in == 8'hFF ? 254 : int'(bus.ui_in);
        r = m_n;
        m_exp = '0;
        for (int k = 0; k < 7; k++) begin
          q = r / (1 << k);
          if (q % 2 == 1) begin
            if (m_s[k]) m_exp[2*k] = 1'b1;
            else m_exp[2*k+1] = 1'b1;
            m_s[k] = !m_s[k];
            r -= 1 << k;
          end else if (r > 2 * (128 - (1 << (k + 1)))) begin
            m_exp[2*k] = 1'b1;
            m_exp[2*k+1] = 1'b1;
            r -= 2 << k;
          end
        end
      end else begin
        m_exp = '0;
        m_n = 0;
      end
    end
  end
  bit have_last [7];
  bit last_a [7];
  always @(negedge clk) begin
    logic [13:0] cur;
    if (m_valid) begin
      chk("uo_out", int'(bus.uo_out), int'(m_exp[13:6]));
      chk("uio_out", int'(bus.uio_out), int'({m_exp[5:0], 2'b00}));
      chk("uio_oe", int'(bus.uio_oe), 32'hFC);
      chk("dac_v", dac_v(bus.uo_out, bus.uio_out), m_n);
      cur = {bus.uo_out, bus.uio_out[7:2]};
      for (int k = 0; k < 7; k++) begin
        if (m_rst) have_last[k] = 0;
        else if (cur[2*k+1] ^ cur[2*k]) begin
          if (have_last[k]) chk("alt_ab", int'(cur[2*k+1]), int'(!last_a[k]));
          last_a[k] = cur[2*k+1];
          have_last[k] = 1;
        end
      end
    end
  end
  task automatic tick(input logic [7:0] u, input logic e, input logic rs);
    bus.ui_in = u;
    bus.ena = e;
    bus.uio_in = 8'($urandom);
    rst_n = rs;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic lit(input string nm, input logic [7:0] uo, input logic [7:0] uio, input int v);
    chk({nm, "_uo"}, int'(bus.uo_out), int'(uo));
    chk({nm, "_uio"}, int'(bus.uio_out), int'(uio));
    chk({nm, "_v"}, dac_v(bus.uo_out, bus.uio_out), v);
  endtask
  initial begin
    logic [7:0] odd_seq [4];
    logic [7:0] three_seq [3];
    odd_seq = '{8'h08, 8'h04, 8'h08, 8'h04};
    three_seq = '{8'h28, 8'h14, 8'h28};
    bus.ena = 1'b0;
    bus.ui_in = '0;
    bus.uio_in = '0;
    rst_n = 1'b1;
    tick(8'h00, 1'b1, 1'b1);
    tick(8'h00, 1'b1, 1'b1);
    lit("reset", 8'h00, 8'h00, 0);
    chk("reset_oe", int'(bus.uio_oe), 32'hFC);
    for (int i = 0; i < 4; i++) begin
      tick(8'h01, 1'b1, 1'b0);
      lit("odd1", 8'h00, odd_seq[i], 1);
    end
    tick(8'hFE, 1'b1, 1'b0);
    lit("full", 8'hFF, 8'hFC, 254);
    tick(8'hFF, 1'b1, 1'b0);
    lit("clamp", 8'hFF, 8'hFC, 254);
    tick(8'h80, 1'b1, 1'b0);
    lit("mid", 8'hC0, 8'h00, 128);
    for (int i = 0; i < 3; i++) begin
      tick(8'h03, 1'b1, 1'b0);
      lit("odd3", 8'h00, three_seq[i], 3);
    end
    for (int i = 0; i < 3; i++) begin
      tick(8'h03, 1'b0, 1'b0);
      lit("frozen", 8'h00, 8'h00, 0);
    end
    tick(8'h03, 1'b1, 1'b0);
    lit("resume", 8'h00, 8'h14, 3);
    for (int i = 0; i < 10000; i++)
      tick($urandom_range(0, 31) == 0 ? 8'hFF : 8'($urandom_range(0, 254)),
           $urandom_range(0, 15) != 0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tt_um_ejfogleman_smsdac8_core.md
TT_UM_EJFOGLEMAN_SMSDAC8_CORE -- requirements
Module: tt_um_ejfogleman_smsdac8

Interface
REQ-001 SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-003 rst_n  input  1  synchronous active-high reset (asserted when 1, despite the name).
REQ-004 ena  input  1  enable; 1 = run, 0 = freeze state and blank outputs.
REQ-005 ui_in  input  8  unsigned DAC input code x.
REQ-006 uio_in  input  8  unused, ignored.
REQ-007 uo_out  output  8  unit-element drives, weights [7:6]=64, [5:4]=32, [3:2]=16, [1:0]=8.
REQ-008 uio_out  output  8  unit-element drives, weights [7:6]=4, [5:4]=2, [3:2]=1; [1:0] tied 0.
REQ-009 uio_oe  output  8  constant 8'b1111_1100.

Function
REQ-010 SHALL drive 14 elements as 7 pairs k=0..6, weight 2^k; pair element A = higher bit index, B = lower bit index.
REQ-011 Effective code SHALL be n = min(x, 254); code 255 is clamped to 254.
REQ-012 Sum of weights of all asserted elements (dac_v) SHALL equal n for every enabled cycle.
REQ-013 Layer decomposition, k = 0 to 6, starting with r = n: q = r / 2^k; element count c_k per pair is computed below; then r = r - c_k*2^k.
REQ-014 If q is odd, c_k SHALL be 1: element A if s_k=0, element B if s_k=1; s_k SHALL then toggle (first-order mismatch shaping).
REQ-015 If q is even, c_k SHALL be 2 when r > 2*(128 - 2^(k+1)) (capacity of higher pairs), else 0.
REQ-016 s_k SHALL be held whenever pair k's count is 0 or 2.
REQ-017 Outputs SHALL be registered with one-cycle latency: values after edge N reflect ui_in sampled at edge N.
REQ-018 With ena=0 at an edge, uo_out and uio_out[7:2] SHALL register 0, and s_k and any LFSR state SHALL hold.
REQ-019 Logic SHALL be fully combinational between the input sample and the output registers; no handshake.

Reset
REQ-020 With rst_n=1 at an edge: uo_out=0x00, uio_out=0x00, all s_k=0, LFSR = seed.
REQ-021 Reset SHALL take priority over ena; the first enabled edge after reset SHALL produce output for the current ui_in.
REQ-022 uio_oe SHALL be 0xFC at all times, including during reset.

Configuration
REQ-023 Macro SMSDAC_DITHER_EN, when defined, SHALL add a 16-bit Fibonacci LFSR with taps 16,14,13,11 and seed 0xACE1.
REQ-024 With the macro defined, the LFSR SHALL advance once per enabled cycle.
REQ-025 With the macro defined, the s_k toggle from REQ-014 SHALL be suppressed when LFSR bit k = 1.
REQ-026 REQ-012 SHALL still hold with the macro defined.
REQ-027 Without the macro, no LFSR SHALL exist and toggling SHALL be deterministic per REQ-014.

Verification (default build, no macro)
REQ-028 Reset: rst_n=1 for 2 cycles -> uo_out=0x00, uio_out=0x00, uio_oe=0xFC.
REQ-029 Odd code: ui_in=0x01 held, ena=1 -> uio_out sequence 0x08, 0x04, 0x08, 0x04 (dac_v=1 each cycle); uo_out=0x00.
REQ-030 Full scale and clamp: ui_in=0xFE -> uo_out=0xFF, uio_out=0xFC, dac_v=254; ui_in=0xFF -> same.
REQ-031 Midscale: ui_in=0x80 -> uo_out=0xC0, uio_out=0x00.
REQ-032 Random codes 0..254 over 10k cycles -> dac_v equals ui_in of the previous edge; each pair's single-element selections alternate A/B.
REQ-033 ena=0 for 3 cycles mid-sequence with odd code 0x03 -> outputs 0; after ena=1, A/B alternation resumes from the held s_k.
